iram_loadable: RTL
==================

# iram_loadable

Parametrised, loadable instruction RAM for the processor's fetch stage. It generalises the hard-initialised 20-bit instruction store:
- width, depth and END opcode are parameters;
- a sequential program-load port replaces fixed initial contents;
- fetches use a registered request/valid handshake;
- a state machine halts fetching once the END instruction has been delivered.

## Interface
Parameters:
- INSTR_W, 20: instruction width in bits
- ADDR_W, 6: PC / load-pointer width
- DEPTH, 46: number of words implemented; must satisfy DEPTH <= 2**ADDR_W
- OPC_W, 4: opcode field width, taken from the instruction MSBs
- END_OPC, 4'b1110: opcode that halts fetching

Ports:
- clk  in  1  rising-edge clock; the block uses one clock only
- rst_n  in  1  asynchronous, active-low reset
- prog_start  in  1  one-cycle pulse; abort whatever is running and enter LOAD with the load pointer cleared
- ld_valid  in  1  ld_data is valid this cycle
- ld_data  in  INSTR_W  word to write at the load pointer
- ld_last  in  1  qualifies ld_valid; the current word is the final word of the program
- fetch_req  in  1  fetch request
- PC  in  ADDR_W  fetch address, sampled when fetch_req=1
- instr_out  out  INSTR_W  fetched instruction (registered)
- instr_valid  out  1  instr_out is new this cycle (1-cycle pulse)
- ready  out  1  state==RUN
- halted  out  1  state==HALT
- ld_ovf  out  1  sticky load-overflow flag
- pc_fault  out  1  out-of-range fetch (see Configuration)

## Operation
States are LOAD, RUN and HALT. Reset enters LOAD.
- **LOAD**
  - ld_valid=1: write ld_data to ram[ld_ptr], then ld_ptr += 1.
  - ld_valid & ld_last: write the word, then go to RUN.
  - Write of the last location (ld_ptr==DEPTH-1) without ld_last: write the word, set ld_ovf, go to RUN.
  - fetch_req is ignored; instr_valid stays 0.
- **RUN**
  - fetch_req=1: instr_out <= ram[PC] and instr_valid <= 1 on the next edge.
  - If the fetched word's opcode field (bits INSTR_W-1 : INSTR_W-OPC_W) equals END_OPC:
    - the END word is still delivered with instr_valid=1;
    - go to HALT on the same edge.
  - ld_valid is ignored.
- **HALT**
  - fetch_req and ld_valid are ignored.
  - instr_out holds the END word.
  - The state is left only via prog_start or reset.
- **prog_start**
  - From any state: go to LOAD, ld_ptr <= 0, ld_ovf <= 0.
  - Takes priority over a simultaneous fetch_req, ld_valid or END detection.
  - A fetch requested in that cycle produces no instr_valid.
- **Memory contents**
  - RAM contents are not affected by reset or prog_start.
  - Words not rewritten keep their old values.
  - A shorter reload leaves stale words above the new program.
- **Outputs between fetches**
  - With no fetch, instr_out holds its last value and instr_valid=0.

## Timing
- Fetch latency is 1 cycle: a request at edge n gives instr_out/instr_valid after edge n+1.
- Back-to-back fetches give one result per cycle.
- A load write completes at the edge where ld_valid=1.
- A fetch issued in the cycle after the ld_last edge reads the just-written word.
- Reset values:
  - instr_out=0, instr_valid=0, ready=0, halted=0, ld_ovf=0, pc_fault=0;
  - ld_ptr=0; state=LOAD.
- Reset asserted mid-fetch or mid-load:
  - outputs clear asynchronously;
  - a partially loaded program remains in RAM, but the block must be reloaded before it will fetch.
- ready and halted are decoded from the state register (glitch-free, registered).

## Configuration
- IRAM_BOUNDS_CHECK_EN defined:
  - a RUN fetch with PC >= DEPTH returns instr_out=0 and instr_valid=1;
  - pc_fault pulses 1 for that cycle;
  - no halt and no memory access.
- IRAM_BOUNDS_CHECK_EN undefined:
  - pc_fault is tied to 0;
  - an out-of-range fetch returns unspecified data with instr_valid=1;
  - the halt check still applies to whatever is read.

## Test plan
- Reset, then load 3 words 0x31000, 0x32400, 0xE0000 (last) -> ready=1 after the 3rd edge; ld_ovf=0.
- RUN: fetch PC=0,1 back-to-back -> instr_out=0x31000 then 0x32400, instr_valid high 2 cycles, 1-cycle latency.
- Fetch PC=2 (0xE0000) -> instr_valid=1 with 0xE0000, halted=1; a further fetch PC=0 gives no instr_valid.
- prog_start together with fetch_req in RUN -> LOAD, no instr_valid; reload 0x12345 (last), fetch PC=0 -> 0x12345.
- Load DEPTH=46 words without ld_last -> ld_ovf=1, ready=1; word 45 reads back correctly.
- With IRAM_BOUNDS_CHECK_EN: fetch PC=50 -> instr_out=0, pc_fault=1 for 1 cycle, halted=0.

Source files
------------

// File: rtl/iram_loadable.sv
// ---------------------------------------------------------------------------
// iram_loadable
//   Loadable instruction RAM for the fetch stage. A program is streamed in
//   through the sequential load port. Fetches then use a registered
//   request/valid handshake. Fetching stops once an END-opcode word has been
//   delivered, and only prog_start or reset restarts the block.
//
//   Optional feature: define IRAM_BOUNDS_CHECK_EN to enable PC range
//   checking. Out-of-range fetches then return 0 and pulse pc_fault.
//   Without it, pc_fault is tied to 0.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   LOAD  | accepting program words at ld_ptr; fetches ignored
//   RUN   | serving fetch requests; END opcode moves to HALT
//   HALT  | END word delivered; everything but prog_start ignored
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   prog_start   in   pulse: abort, clear load pointer/overflow, enter LOAD
//   ld_valid     in   ld_data valid this cycle
//   ld_data      in   [INSTR_W] word written at the load pointer
//   ld_last      in   current load word is the final program word
//   fetch_req    in   fetch request
//   PC           in   [ADDR_W] fetch address
//   instr_out    out  [INSTR_W] registered fetched instruction
//   instr_valid  out  one-cycle pulse: instr_out is new
//   ready        out  state is RUN
//   halted       out  state is HALT
//   ld_ovf       out  sticky: memory filled without ld_last
//   pc_fault     out  out-of-range fetch pulse (bounds-check build only)
// ---------------------------------------------------------------------------
module iram_loadable #(
  parameter int               INSTR_W = 20,
  parameter int               ADDR_W  = 6,
  parameter int               DEPTH   = 46,
  parameter int               OPC_W   = 4,
  parameter logic [OPC_W-1:0] END_OPC = 4'b1110
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_start,
  input  logic               ld_valid,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               ld_last,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  PC,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               ready,
  output logic               halted,
  output logic               ld_ovf,
  output logic               pc_fault
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  // One bit per non-LOAD state so ready/halted come straight off flops.
  typedef enum logic [1:0] {
    LOAD = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [INSTR_W-1:0] ram [DEPTH];
  logic [ADDR_W-1:0]  ld_ptr;
  logic               wr_en;
  logic               fetch_en;
  logic               pc_in_range;
  logic               pc_oob;
  logic [INSTR_W-1:0] rd_word;

  assign pc_in_range = {1'b0, PC} < DEPTH_EXT;
  assign rd_word     = pc_in_range ? ram[PC] : '0;

`ifdef IRAM_BOUNDS_CHECK_EN
  assign pc_oob = ~pc_in_range;
`else
  assign pc_oob = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    fetch_en  = 1'b0;
    if (prog_start) begin
      state_nxt = LOAD;
    end else begin
      unique case (state)
        LOAD: begin
          if (ld_valid) begin
            wr_en = 1'b1;
            if (ld_last || (ld_ptr == LAST_PTR)) state_nxt = RUN;
          end
        end
        RUN: begin
          if (fetch_req) begin
            fetch_en = 1'b1;
            // The END word itself is still delivered; only later fetches stop.
            if (!pc_oob && (rd_word[INSTR_W-1 -: OPC_W] == END_OPC))
              state_nxt = HALT;
          end
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = LOAD;
      endcase
    end
  end

  assign ready  = state[0];
  assign halted = state[1];

  // Program storage is deliberately not reset; stale words survive reloads.
  always_ff @(posedge clk) begin
    if (wr_en) ram[ld_ptr] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ptr      <= '0;
      ld_ovf      <= 1'b0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= fetch_en;
      if (fetch_en) instr_out <= pc_oob ? '0 : rd_word;
      if (prog_start) begin
        ld_ptr <= '0;
        ld_ovf <= 1'b0;
      end else if (wr_en) begin
        ld_ptr <= ld_ptr + ADDR_W'(1);
        if ((ld_ptr == LAST_PTR) && !ld_last) ld_ovf <= 1'b1;
      end
    end
  end

`ifdef IRAM_BOUNDS_CHECK_EN
  logic pc_fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_fault_q <= 1'b0;
    else        pc_fault_q <= fetch_en & pc_oob;
  end
  assign pc_fault = pc_fault_q;
`else
  assign pc_fault = 1'b0;
`endif

endmodule
